// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, functs, ALUOp values,
// the mul/div sequencer state and the per-instruction control bundle.
package ctrl_pkg;

    localparam int ALUOP_WIDTH = 2;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic                   regdst;
        logic                   branch;
        logic                   memread;
        logic                   memtoreg;
        logic                   memwrite;
        logic                   alusrc;
        logic                   regwrite;
        logic                   jump;
        logic                   shift;
        logic                   jal;
        logic [ALUOP_WIDTH-1:0] aluop;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

    function automatic logic is_muldiv_funct(input logic [5:0] fn);
        return fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode/funct decoder: produces the control bundle, the resolved
// destination register and the hazard-relevant flags for the instruction sitting in ID.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output ctrl_bundle_t      ctrl,
    output logic [REG_AW-1:0] dst,
    output logic              uses_rt,
    output logic              is_muldiv,
    output logic              md_dep
);

    always_comb begin
        ctrl      = CTRL_NOP;
        dst       = '0;
        uses_rt   = 1'b0;
        is_muldiv = 1'b0;
        md_dep    = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                uses_rt   = 1'b1;
                is_muldiv = is_muldiv_funct(funct);
                md_dep    = is_muldiv_funct(funct) || (funct inside {FN_MFHI, FN_MFLO});
                if (funct == FN_JR) begin
                    ctrl.jump = 1'b1;
                end else if (funct == FN_JALR) begin
                    ctrl.regdst   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.jump     = 1'b1;
                    ctrl.jal      = 1'b1;
                    dst           = rd;
                end else if (!is_muldiv_funct(funct)) begin
                    // MULT/DIV write HI/LO only, so they carry no register-file controls
                    ctrl.regdst   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_FUNCT;
                    ctrl.shift    = funct inside {FN_SLL, FN_SRL, FN_SRA};
                    dst           = rd;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                dst           = rt;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
                dst           = rt;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALUOP_SUB;
                uses_rt     = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.jal      = 1'b1;
                ctrl.regwrite = 1'b1;
                dst           = REG_AW'(LINK_REG);
            end
            default: begin
                ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control unit: ID/EX control register, load-use / flush / stall handling and,
// when CTRL_MULDIV_EN is defined, the multi-cycle MULT/DIV occupancy sequencer.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int ALUOP_W       = 2,
    parameter int MULDIV_CYCLES = 32,
    parameter int LINK_REG      = 31
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [REG_AW-1:0]  rs,
    input  logic [REG_AW-1:0]  rt,
    input  logic [REG_AW-1:0]  rd,
    input  logic               flush,
    input  logic               stall_ext,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ex_valid,
    output logic               ex_regdst,
    output logic               ex_branch,
    output logic               ex_memread,
    output logic               ex_memtoreg,
    output logic               ex_memwrite,
    output logic               ex_alusrc,
    output logic               ex_regwrite,
    output logic               ex_jump,
    output logic               ex_shift,
    output logic               ex_jal,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]  ex_dst,
    output logic               muldiv_start,
    output logic               muldiv_busy
);

    ctrl_bundle_t      dec_ctrl;
    logic [REG_AW-1:0] dec_dst;
    logic              dec_uses_rt;
    logic              dec_is_muldiv;
    logic              dec_md_dep;

    ctrl_decode_comb #(
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .rt        (rt),
        .rd        (rd),
        .ctrl      (dec_ctrl),
        .dst       (dec_dst),
        .uses_rt   (dec_uses_rt),
        .is_muldiv (dec_is_muldiv),
        .md_dep    (dec_md_dep)
    );

    logic              ex_valid_q, ex_valid_d;
    ctrl_bundle_t      ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
    logic              load_use;
    logic              md_stall;
    logic              load_ok;

    // A load only hurts if it writes a real register that the ID instruction reads
    assign load_use = instr_valid && ex_valid_q && ex_ctrl_q.memread && (ex_dst_q != '0) &&
                      ((ex_dst_q == rs) || (dec_uses_rt && (ex_dst_q == rt)));

    assign load_ok    = !flush && !stall_ext && !md_stall && !load_use && instr_valid;
    assign pc_write   = flush || !(stall_ext || load_use || md_stall);
    assign ifid_write = flush || !(stall_ext || load_use || md_stall);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_dst_d   = ex_dst_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NOP;
            ex_dst_d   = '0;
        end else if (stall_ext) begin
            ex_valid_d = ex_valid_q;
        end else if (load_ok) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = dec_ctrl;
            ex_dst_d   = dec_dst;
        end else begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NOP;
            ex_dst_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
            ex_dst_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_dst_q   <= ex_dst_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regdst   = ex_ctrl_q.regdst;
    assign ex_branch   = ex_ctrl_q.branch;
    assign ex_memread  = ex_ctrl_q.memread;
    assign ex_memtoreg = ex_ctrl_q.memtoreg;
    assign ex_memwrite = ex_ctrl_q.memwrite;
    assign ex_alusrc   = ex_ctrl_q.alusrc;
    assign ex_regwrite = ex_ctrl_q.regwrite;
    assign ex_jump     = ex_ctrl_q.jump;
    assign ex_shift    = ex_ctrl_q.shift;
    assign ex_jal      = ex_ctrl_q.jal;
    assign ex_aluop    = ALUOP_W'(ex_ctrl_q.aluop);
    assign ex_dst      = ex_dst_q;

`ifdef CTRL_MULDIV_EN
    localparam int                CNT_W    = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;

    // Anything touching HI/LO while the unit is occupied waits as a bubble
    assign md_stall = (state_q == BUSY) && instr_valid && dec_md_dep;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ok && dec_is_muldiv) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    start_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign muldiv_start = start_q;
    assign muldiv_busy  = (state_q == BUSY);
`else
    logic md_unused;

    assign md_stall     = 1'b0;
    assign muldiv_start = 1'b0;
    assign muldiv_busy  = 1'b0;
    assign md_unused    = &{1'b0, dec_is_muldiv, dec_md_dep, (MULDIV_CYCLES > 1)};
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed scenarios plus a randomized run
// against an instruction-level reference model of the ID/EX control behaviour.
module tb_ctrl_decode_pipe;

    localparam int MD_CYCLES = 4;
`ifdef CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic       regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, jump, shift, jal;
        logic [1:0] aluop;
    } ctl_t;

    logic       clk, reset_n, instr_valid, flush, stall_ext;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       pc_write, ifid_write, ex_valid;
    logic       ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
    logic       ex_alusrc, ex_regwrite, ex_jump, ex_shift, ex_jal;
    logic [1:0] ex_aluop;
    logic [4:0] ex_dst;
    logic       muldiv_start, muldiv_busy;
    ctl_t       ex_act;

    assign ex_act = {ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
                     ex_alusrc, ex_regwrite, ex_jump, ex_shift, ex_jal, ex_aluop};

    ctrl_decode_pipe #(
        .REG_AW(5), .ALUOP_W(2), .MULDIV_CYCLES(MD_CYCLES), .LINK_REG(31)
    ) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .stall_ext(stall_ext),
        .pc_write(pc_write), .ifid_write(ifid_write), .ex_valid(ex_valid),
        .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_jump(ex_jump), .ex_shift(ex_shift), .ex_jal(ex_jal),
        .ex_aluop(ex_aluop), .ex_dst(ex_dst), .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: what ID/EX and the HI/LO unit should hold
    bit         m_valid;
    ctl_t       m_ctl;
    logic [4:0] m_dst;
    int         m_busy_left;
    bit         m_start;

    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] t, input logic [4:0] dd,
                                       output ctl_t c, output logic [4:0] d,
                                       output bit urt, output bit md, output bit dep);
        bit is_md;
        c = '0; d = '0; urt = 0; md = 0; dep = 0;
        is_md = fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011};
        if (op == 6'b000000) begin
            urt = 1;
            md  = MD_EN && is_md;
            dep = MD_EN && (is_md || (fn inside {6'b010000, 6'b010010}));
            if (fn == 6'b001000) c.jump = 1;
            else if (fn == 6'b001001) begin
                c.regdst = 1; c.regwrite = 1; c.jump = 1; c.jal = 1; d = dd;
            end else if (!is_md) begin
                c.regdst = 1; c.regwrite = 1; c.aluop = 2'b10; d = dd;
                c.shift = fn inside {6'b000000, 6'b000010, 6'b000011};
            end
        end else if (op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111}) begin
            c.memread = 1; c.memtoreg = 1; c.alusrc = 1; c.regwrite = 1; d = t;
        end else if (op inside {6'b101000, 6'b101001, 6'b101011}) begin
            c.memwrite = 1; c.alusrc = 1; urt = 1;
        end else if (op inside {6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111}) begin
            c.alusrc = 1; c.regwrite = 1; c.aluop = 2'b10; d = t;
        end else if (op inside {6'b000100, 6'b000101}) begin
            c.branch = 1; c.aluop = 2'b01; urt = 1;
        end else if (op == 6'b000010) begin
            c.jump = 1;
        end else if (op == 6'b000011) begin
            c.jump = 1; c.jal = 1; c.regwrite = 1; d = 5'd31;
        end
    endfunction

    // True when the ID instruction must wait (load-use or HI/LO dependency on a busy unit)
    function automatic bit ref_id_blocked();
        ctl_t c; logic [4:0] d; bit urt, md, dep, haz;
        ref_decode(opcode, funct, rt, rd, c, d, urt, md, dep);
        haz = instr_valid && m_valid && m_ctl.memread && (m_dst != 0) &&
              ((m_dst == rs) || (urt && (m_dst == rt)));
        return haz || (instr_valid && (m_busy_left > 0) && dep);
    endfunction

    function automatic bit ref_pc_write();
        return flush || !(stall_ext || ref_id_blocked());
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctl = '0; m_dst = '0; m_busy_left = 0; m_start = 0;
    endtask

    task automatic model_edge();
        ctl_t c; logic [4:0] d; bit urt, md, dep, blocked, busy_now, issue;
        ref_decode(opcode, funct, rt, rd, c, d, urt, md, dep);
        blocked  = ref_id_blocked();
        busy_now = m_busy_left > 0;
        issue    = 0;
        if (flush) begin
            m_valid = 0; m_ctl = '0; m_dst = '0;
        end else if (!stall_ext) begin
            if (blocked || !instr_valid) begin
                m_valid = 0; m_ctl = '0; m_dst = '0;
            end else begin
                m_valid = 1; m_ctl = c; m_dst = d; issue = md;
            end
        end
        m_start = issue;
        if (issue) m_busy_left = MD_CYCLES;
        else if (busy_now) m_busy_left = m_busy_left - 1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] dd);
        instr_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = dd;
    endtask

    task automatic test_reset();
        reset_n = 0; flush = 0; stall_ext = 0;
        drive(0, 6'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        #3;
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset ex_valid: got %b want 0", ex_valid); end
        n_tests++; if (ex_act !== 12'h000) begin n_fail++; $display("[TB] FAIL reset ex_ctrl: got %h want 000", ex_act); end
        n_tests++; if (ex_dst !== 5'd0) begin n_fail++; $display("[TB] FAIL reset ex_dst: got %0d want 0", ex_dst); end
        n_tests++; if ({muldiv_start, muldiv_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset muldiv: got %b want 00", {muldiv_start, muldiv_busy}); end
        n_tests++; if ({pc_write, ifid_write} !== 2'b11) begin n_fail++; $display("[TB] FAIL reset writes: got %b want 11", {pc_write, ifid_write}); end
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_load_decode();
        drive(1, 6'b100011, 6'b000000, 5'd0, 5'd8, 5'd0);
        tick();
        n_tests++; if ({ex_memread, ex_memtoreg, ex_regwrite, ex_valid} !== 4'b1111) begin n_fail++; $display("[TB] FAIL lw_decode flags: got %b want 1111", {ex_memread, ex_memtoreg, ex_regwrite, ex_valid}); end
        n_tests++; if (ex_dst !== 5'd8) begin n_fail++; $display("[TB] FAIL lw_decode ex_dst: got %0d want 8", ex_dst); end
    endtask

    task automatic test_load_use();
        drive(1, 6'b000000, 6'b100000, 5'd8, 5'd1, 5'd3);
        #1;
        n_tests++; if ({pc_write, ifid_write} !== 2'b00) begin n_fail++; $display("[TB] FAIL load_use hold: got %b want 00", {pc_write, ifid_write}); end
        tick();
        n_tests++; if ({ex_valid, ex_memread} !== 2'b00) begin n_fail++; $display("[TB] FAIL load_use bubble: got %b want 00", {ex_valid, ex_memread}); end
        n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("[TB] FAIL load_use release: got %b want 1", pc_write); end
        tick();
        n_tests++; if ({ex_valid, ex_regdst, ex_regwrite} !== 3'b111 || ex_dst !== 5'd3 || ex_aluop !== 2'b10) begin n_fail++; $display("[TB] FAIL load_use add: got %b dst %0d aluop %b want 111 dst 3 aluop 10", {ex_valid, ex_regdst, ex_regwrite}, ex_dst, ex_aluop); end
    endtask

    task automatic test_zero_reg();
        drive(1, 6'b100011, 6'b000000, 5'd2, 5'd0, 5'd0);
        tick();
        drive(1, 6'b000000, 6'b100000, 5'd0, 5'd0, 5'd5);
        #1;
        n_tests++; if ({pc_write, ifid_write} !== 2'b11) begin n_fail++; $display("[TB] FAIL zero_reg writes: got %b want 11", {pc_write, ifid_write}); end
        tick();
        n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd5) begin n_fail++; $display("[TB] FAIL zero_reg issue: got v%b dst %0d want v1 dst 5", ex_valid, ex_dst); end
    endtask

    task automatic test_flush_priority();
        drive(1, 6'b100011, 6'b000000, 5'd0, 5'd8, 5'd0);
        tick();
        drive(1, 6'b000000, 6'b100000, 5'd8, 5'd1, 5'd3);
        flush = 1; stall_ext = 1;
        #1;
        n_tests++; if ({pc_write, ifid_write} !== 2'b11) begin n_fail++; $display("[TB] FAIL flush writes: got %b want 11", {pc_write, ifid_write}); end
        tick();
        flush = 0; stall_ext = 0;
        n_tests++; if (ex_valid !== 1'b0 || ex_act !== 12'h000) begin n_fail++; $display("[TB] FAIL flush bubble: got v%b ctrl %h want v0 ctrl 000", ex_valid, ex_act); end
    endtask

    task automatic test_stall_ext();
        drive(1, 6'b000100, 6'b000000, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1, 6'b001000, 6'b000000, 5'd3, 5'd4, 5'd0);
        stall_ext = 1;
        #1;
        n_tests++; if ({pc_write, ifid_write} !== 2'b00) begin n_fail++; $display("[TB] FAIL stall_ext writes: got %b want 00", {pc_write, ifid_write}); end
        tick();
        stall_ext = 0;
        n_tests++; if ({ex_valid, ex_branch, ex_alusrc} !== 3'b110 || ex_aluop !== 2'b01) begin n_fail++; $display("[TB] FAIL stall_ext hold: got %b aluop %b want 110 aluop 01", {ex_valid, ex_branch, ex_alusrc}, ex_aluop); end
    endtask

    task automatic test_jumps();
        drive(1, 6'b000011, 6'b000000, 5'd0, 5'd0, 5'd0);
        tick();
        n_tests++; if ({ex_jump, ex_jal, ex_regwrite} !== 3'b111 || ex_dst !== 5'd31) begin n_fail++; $display("[TB] FAIL jal: got %b dst %0d want 111 dst 31", {ex_jump, ex_jal, ex_regwrite}, ex_dst); end
        drive(1, 6'b000000, 6'b001000, 5'd4, 5'd0, 5'd0);
        tick();
        n_tests++; if ({ex_jump, ex_regwrite, ex_jal} !== 3'b100) begin n_fail++; $display("[TB] FAIL jr: got %b want 100", {ex_jump, ex_regwrite, ex_jal}); end
        drive(1, 6'b001001, 6'b000000, 5'd1, 5'd2, 5'd3);
        tick();
        n_tests++; if (ex_valid !== 1'b1 || ex_act !== 12'h000) begin n_fail++; $display("[TB] FAIL unknown_op: got v%b ctrl %h want v1 ctrl 000", ex_valid, ex_act); end
        drive(0, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
        tick();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL invalid bubble: got %b want 0", ex_valid); end
    endtask

    task automatic test_muldiv();
        drive(0, 6'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1, 6'b000000, 6'b011000, 5'd1, 5'd2, 5'd0);
        tick();
`ifdef CTRL_MULDIV_EN
        n_tests++; if ({muldiv_start, muldiv_busy, ex_valid} !== 3'b111) begin n_fail++; $display("[TB] FAIL mult issue: got %b want 111", {muldiv_start, muldiv_busy, ex_valid}); end
        drive(1, 6'b000000, 6'b010010, 5'd0, 5'd0, 5'd4);
        for (int i = 0; i < MD_CYCLES; i++) begin
            #1;
            n_tests++; if (muldiv_busy !== 1'b1 || muldiv_start !== (i == 0)) begin n_fail++; $display("[TB] FAIL busy cycle %0d: got busy %b start %b want 1 %b", i, muldiv_busy, muldiv_start, (i == 0)); end
            n_tests++; if (pc_write !== 1'b0) begin n_fail++; $display("[TB] FAIL mflo stall %0d: got %b want 0", i, pc_write); end
            tick();
            n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mflo bubble %0d: got %b want 0", i, ex_valid); end
        end
        n_tests++; if ({muldiv_busy, pc_write} !== 2'b01) begin n_fail++; $display("[TB] FAIL busy end: got %b want 01", {muldiv_busy, pc_write}); end
        tick();
        n_tests++; if ({ex_valid, ex_regdst} !== 2'b11 || ex_dst !== 5'd4) begin n_fail++; $display("[TB] FAIL mflo issue: got %b dst %0d want 11 dst 4", {ex_valid, ex_regdst}, ex_dst); end
        drive(1, 6'b000000, 6'b011010, 5'd1, 5'd2, 5'd0);
        tick();
        drive(0, 6'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
        reset_n = 0;
        model_reset();
        #1;
        n_tests++; if ({muldiv_busy, muldiv_start} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset mid-busy: got %b want 00", {muldiv_busy, muldiv_start}); end
        @(negedge clk);
        reset_n = 1;
        tick();
`else
        n_tests++; if (ex_valid !== 1'b1 || ex_act !== 12'h000) begin n_fail++; $display("[TB] FAIL mult disabled: got v%b ctrl %h want v1 ctrl 000", ex_valid, ex_act); end
        n_tests++; if ({muldiv_start, muldiv_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL muldiv tied: got %b want 00", {muldiv_start, muldiv_busy}); end
        drive(1, 6'b000000, 6'b010010, 5'd0, 5'd0, 5'd4);
        #1;
        n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("[TB] FAIL mflo no stall: got %b want 1", pc_write); end
        tick();
`endif
    endtask

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 11))
            0:  return 6'b100000;
            1:  return 6'b100010;
            2:  return 6'b000000;
            3:  return 6'b000010;
            4:  return 6'b001000;
            5:  return 6'b001001;
            6:  return 6'b011000;
            7:  return 6'b011011;
            8:  return 6'b010000;
            9:  return 6'b010010;
            10: return 6'b000011;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [5:0] pick_opcode();
        case ($urandom_range(0, 13))
            0, 1, 2: return 6'b000000;
            3:  return 6'b100011;
            4:  return 6'b100000;
            5:  return 6'b101011;
            6:  return 6'b001000;
            7:  return 6'b001101;
            8:  return 6'b000100;
            9:  return 6'b000101;
            10: return 6'b000010;
            11: return 6'b000011;
            12: return 6'b001001;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic test_random();
        bit exp_w;
        @(negedge clk);
        reset_n = 0; flush = 0; stall_ext = 0;
        model_reset();
        #2;
        reset_n = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 7) != 0, pick_opcode(), pick_funct(),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            flush     = ($urandom_range(0, 9) == 0);
            stall_ext = ($urandom_range(0, 7) == 0);
            #1;
            exp_w = ref_pc_write();
            n_tests++; if (pc_write !== exp_w) begin n_fail++; $display("[TB] FAIL rand pc_write c%0d: got %b want %b", cyc, pc_write, exp_w); end
            n_tests++; if (ifid_write !== exp_w) begin n_fail++; $display("[TB] FAIL rand ifid_write c%0d: got %b want %b", cyc, ifid_write, exp_w); end
            tick();
            n_tests++; if (ex_valid !== m_valid) begin n_fail++; $display("[TB] FAIL rand ex_valid c%0d: got %b want %b", cyc, ex_valid, m_valid); end
            n_tests++; if (ex_act !== m_ctl) begin n_fail++; $display("[TB] FAIL rand ex_ctrl c%0d: got %h want %h", cyc, ex_act, m_ctl); end
            n_tests++; if (ex_dst !== m_dst) begin n_fail++; $display("[TB] FAIL rand ex_dst c%0d: got %0d want %0d", cyc, ex_dst, m_dst); end
            n_tests++; if (muldiv_start !== m_start) begin n_fail++; $display("[TB] FAIL rand muldiv_start c%0d: got %b want %b", cyc, muldiv_start, m_start); end
            n_tests++; if (muldiv_busy !== (m_busy_left > 0)) begin n_fail++; $display("[TB] FAIL rand muldiv_busy c%0d: got %b want %b", cyc, muldiv_busy, (m_busy_left > 0)); end
        end
        flush = 0; stall_ext = 0;
    endtask

    initial begin
        test_reset();
        test_load_decode();
        test_load_use();
        test_zero_reg();
        test_flush_priority();
        test_stall_ext();
        test_jumps();
        test_muldiv();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
